perfmon_histogram: RTL and testbench
====================================

PERFMON_HISTOGRAM -- requirements
Module: perfmon_histogram

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of every histogram/statistics counter and of rd_data.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port enable  input  1  sample qualifier; no counter changes when 0.
REQ-005 SHALL have port clear  input  1  synchronous zeroing of all counters and flags.
REQ-006 SHALL have port max  input  32  capacity of the monitored queue; 0 means degenerate (see REQ-012).
REQ-007 SHALL have port curr  input  32  current occupancy of the monitored queue.
REQ-008 SHALL have port rd_sel  input  4  readout select.
REQ-009 SHALL have port rd_data  output  CNT_W  selected counter value.
REQ-010 SHALL have port sat  output  1  sticky flag: some counter has saturated.

Function
REQ-011 Each cycle with enable=1 and clear=0 SHALL classify curr into exactly one of 10 bins: bin 0 EMPTY if curr==0; bin 9 FULL if curr>=max; otherwise bin 1+q, q = largest k in 0..7 with 8*curr >= k*max, computed at 35 bits with no overflow.
REQ-012 With max==0: curr==0 -> bin 0, any other curr -> bin 9.
REQ-013 The selected bin counter SHALL increment by 1; all other bin counters hold.
REQ-014 A total-samples counter SHALL increment on every qualified cycle.
REQ-015 A peak register SHALL load curr when curr > peak on a qualified cycle; width CNT_W, curr truncated to CNT_W bits if CNT_W<32.
REQ-016 All counters SHALL saturate at all-ones (no wrap); a saturated counter still counts as saturated, and sat SHALL set in the same cycle the saturated value is stored and remain 1 until clear or reset.
REQ-017 clear SHALL have priority over sampling: when clear=1 all bins, total, peak and sat become 0 at the next edge and the current sample is discarded.
REQ-018 Latency: a sample taken at edge N SHALL be visible on rd_data after edge N (zero-cycle combinational readout of registered state).
REQ-019 rd_data mapping: rd_sel 0..9 = bin 0..9; 10 = total samples; 11 = peak; 12..15 = 0.
REQ-020 max and curr SHALL be sampled only when enable=1; changes while enable=0 have no effect.
REQ-021 Invariant: sum of bins 0..9 SHALL equal total until any counter saturates.

Reset
REQ-022 reset=1 at a rising edge SHALL zero all bins, total, peak and sat; it overrides clear and enable.
REQ-023 Outputs after reset: rd_data=0 for every rd_sel, sat=0.
REQ-024 Reset asserted mid-operation SHALL discard that cycle's sample; counting resumes on the first qualified cycle after reset deasserts.

Structure
REQ-025 Shared package perfmon_pkg SHALL hold NBINS=10, bin index constants BIN_EMPTY=0 and BIN_FULL=9, readout codes SEL_TOTAL=10 and SEL_PEAK=11.
REQ-026 Classification SHALL be one combinational sub-module perfmon_bin_classify (inputs max, curr; output 4-bit bin index) using shift/add thresholds, no divider.
REQ-027 Top level holds counters, saturation logic, peak and readout mux only.

Verification
REQ-028 Reset then max=128, enable=1, curr=0 for 5 cycles -> bin0=5, total=5, peak=0, all other bins 0.
REQ-029 max=128, curr=16,32,63,64,127,128,200 one cycle each -> bins 2,3,4,5,8,9,9 increment by 1 each; total=7; peak=200.
REQ-030 max=0, curr=0 then curr=1 -> bin0=1, bin9=1.
REQ-031 CNT_W=4, max=128, curr=128 for 20 cycles -> bin9=15, total=15, sat=1 from the 15th sample onward.
REQ-032 After counting, assert clear with enable=1 and curr=5 -> next cycle all reads 0, sat=0; reset with enable=1 yields same.
REQ-033 enable=0 for 10 cycles with varying curr -> no counter or peak change; rd_sel=12..15 always 0.

Source files
------------

// File: rtl/perfmon_pkg.sv
// -----------------------------------------------------------------------------
// perfmon_pkg
// Shared constants for the queue-occupancy histogram monitor.
//   NBINS      : number of histogram bins
//   BIN_EMPTY  : bin index used when the queue is empty
//   BIN_FULL   : bin index used when the queue is at or above capacity
//   SEL_TOTAL  : readout code for the total-samples counter
//   SEL_PEAK   : readout code for the peak-occupancy register
// -----------------------------------------------------------------------------
package perfmon_pkg;

   localparam int NBINS = 10;

   typedef logic [3:0] bin_idx_t;

   localparam bin_idx_t BIN_EMPTY = 4'd0;
   localparam bin_idx_t BIN_FULL  = 4'd9;
   localparam bin_idx_t SEL_TOTAL = 4'd10;
   localparam bin_idx_t SEL_PEAK  = 4'd11;

endpackage : perfmon_pkg

// File: rtl/perfmon_bin_classify.sv
// -----------------------------------------------------------------------------
// perfmon_bin_classify
// Combinational classifier mapping queue occupancy to a histogram bin.
//   max     : in  32  queue capacity (0 = degenerate, anything nonzero is FULL)
//   curr    : in  32  current occupancy
//   bin_idx : out 4   0 = empty, 9 = full (curr >= max), else 1 + eighth index
// The eighth index q is the largest k in 0..7 with 8*curr >= k*max. The seven
// thresholds k*max are formed from shifted copies of max at 35 bits so that
// 8*curr and 7*max can never overflow; no divider is needed.
// -----------------------------------------------------------------------------
module perfmon_bin_classify
   import perfmon_pkg::*;
(
   input  logic [31:0] max,
   input  logic [31:0] curr,
   output bin_idx_t    bin_idx
);

   logic [34:0] max_w;
   logic [34:0] curr_x8;
   logic [7:1]  step_ge;
   logic [2:0]  eighth;

   assign max_w   = {3'b000, max};
   assign curr_x8 = {curr, 3'b000};

   genvar gi;
   generate
      for (gi = 1; gi < 8; gi++) begin : g_thr
         localparam logic [2:0] K = 3'(gi);
         logic [34:0] thr;
         // k*max as the sum of max, 2*max and 4*max selected by the bits of k
         assign thr = (K[0] ? max_w                  : 35'd0)
                    + (K[1] ? {max_w[33:0], 1'b0}    : 35'd0)
                    + (K[2] ? {max_w[32:0], 2'b00}   : 35'd0);
         assign step_ge[gi] = (curr_x8 >= thr);
      end
   endgenerate

   // Thresholds grow with k, so the highest satisfied one is the eighth index.
   always_comb begin
      eighth = 3'd0;
      for (int k = 1; k < 8; k++) begin
         if (step_ge[k]) begin
            eighth = 3'(k);
         end
      end
   end

   // curr >= max also catches max == 0 for any nonzero curr.
   always_comb begin
      if (curr == 32'd0) begin
         bin_idx = BIN_EMPTY;
      end else if (curr >= max) begin
         bin_idx = BIN_FULL;
      end else begin
         bin_idx = {1'b0, eighth} + 4'd1;
      end
   end

endmodule : perfmon_bin_classify

// File: rtl/perfmon_histogram.sv
// -----------------------------------------------------------------------------
// perfmon_histogram
// Occupancy histogram for a monitored queue with saturating counters.
//   clk     : in  1      sole clock
//   reset   : in  1      synchronous active-high reset, overrides everything
//   enable  : in  1      sample qualifier
//   clear   : in  1      synchronous zeroing of counters/flags, beats enable
//   max     : in  32     queue capacity
//   curr    : in  32     current occupancy
//   rd_sel  : in  4      0..9 bins, 10 total, 11 peak, 12..15 read as 0
//   rd_data : out CNT_W  selected value (combinational from registered state)
//   sat     : out 1      sticky: some bin or the total reached all-ones
// -----------------------------------------------------------------------------
module perfmon_histogram
   import perfmon_pkg::*;
#(
   parameter int CNT_W = 32
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             clear,
   input  logic [31:0]      max,
   input  logic [31:0]      curr,
   input  logic [3:0]       rd_sel,
   output logic [CNT_W-1:0] rd_data,
   output logic             sat
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   bin_idx_t                    bin_idx;
   logic                        sample_en;
   logic [NBINS-1:0][CNT_W-1:0] bin_val;
   logic [NBINS-1:0]            bin_at_max;
   logic [CNT_W-1:0]            total_reg, total_next;
   logic [CNT_W-1:0]            peak_reg, peak_next;
   logic [CNT_W-1:0]            curr_trunc;
   logic                        sat_reg, sat_next;

   perfmon_bin_classify u_classify (
      .max     (max),
      .curr    (curr),
      .bin_idx (bin_idx)
   );

   assign sample_en  = enable & ~clear;
   assign curr_trunc = CNT_W'(curr);

   // One saturating counter per bin.
   genvar gi;
   generate
      for (gi = 0; gi < NBINS; gi++) begin : g_bin
         logic [CNT_W-1:0] cnt_reg, cnt_next;

         always_comb begin
            cnt_next = cnt_reg;
            if (sample_en && (bin_idx == 4'(gi)) && (cnt_reg != CNT_MAX)) begin
               cnt_next = cnt_reg + CNT_ONE;
            end
         end

         always_ff @(posedge clk) begin
            if (reset || clear) begin
               cnt_reg <= '0;
            end else begin
               cnt_reg <= cnt_next;
            end
         end

         assign bin_val[gi]    = cnt_reg;
         assign bin_at_max[gi] = (cnt_next == CNT_MAX);
      end
   endgenerate

   always_comb begin
      total_next = total_reg;
      peak_next  = peak_reg;
      if (sample_en) begin
         if (total_reg != CNT_MAX) begin
            total_next = total_reg + CNT_ONE;
         end
         if (curr_trunc > peak_reg) begin
            peak_next = curr_trunc;
         end
      end
   end

   // Checking the next values lets sat rise with the edge that stores all-ones.
   // A counter already pinned at all-ones keeps this term true, which is
   // harmless because sat is already set by then.
   assign sat_next = sat_reg | (|bin_at_max) | (total_next == CNT_MAX);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         total_reg <= '0;
         peak_reg  <= '0;
         sat_reg   <= 1'b0;
      end else begin
         total_reg <= total_next;
         peak_reg  <= peak_next;
         sat_reg   <= sat_next;
      end
   end

   always_comb begin
      rd_data = '0;
      if (rd_sel <= BIN_FULL) begin
         rd_data = bin_val[rd_sel];
      end else if (rd_sel == SEL_TOTAL) begin
         rd_data = total_reg;
      end else if (rd_sel == SEL_PEAK) begin
         rd_data = peak_reg;
      end
   end

   assign sat = sat_reg;

endmodule : perfmon_histogram

// File: tb/tb_perfmon_histogram.sv
`timescale 1ns/1ps
module tb_perfmon_histogram;

   logic        clk = 1'b0;
   logic        reset, enable, clear;
   logic [31:0] max, curr;
   logic [3:0]  rd_sel;
   logic [31:0] rd_data;
   logic        sat;
   logic [3:0]  rd_data4;
   logic        sat4;

   perfmon_histogram #(.CNT_W(32)) dut (
      .clk(clk), .reset(reset), .enable(enable), .clear(clear),
      .max(max), .curr(curr), .rd_sel(rd_sel), .rd_data(rd_data), .sat(sat)
   );

   perfmon_histogram #(.CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .enable(enable), .clear(clear),
      .max(max), .curr(curr), .rd_sel(rd_sel), .rd_data(rd_data4), .sat(sat4)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int txn      = 0;

   // Reference state per instance: [0] CNT_W=32, [1] CNT_W=4.
   // Entries 0..9 bins, 10 total, 11 peak.
   longint unsigned mdl  [2][12];
   bit              msat [2];
   longint unsigned lim  [2];

   task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Bin from the plain arithmetic definition: eighths of capacity by division.
   function automatic int ref_bin(longint unsigned m, longint unsigned c);
      if (c == 0) return 0;
      if (c >= m) return 9;
      return 1 + int'((8 * c) / m);
   endfunction

   task automatic bump(input int w, input int i);
      if (mdl[w][i] < lim[w]) mdl[w][i]++;
      if (mdl[w][i] == lim[w]) msat[w] = 1'b1;
   endtask

   task automatic model_clock();
      for (int w = 0; w < 2; w++) begin
         if (reset || clear) begin
            for (int i = 0; i < 12; i++) mdl[w][i] = 0;
            msat[w] = 1'b0;
         end else if (enable) begin
            longint unsigned pk;
            bump(w, ref_bin(longint'(max), longint'(curr)));
            bump(w, 10);
            pk = longint'(curr) & lim[w];
            if (pk > mdl[w][11]) mdl[w][11] = pk;
         end
      end
   endtask

   task automatic check_all(input string tag);
      for (int s = 0; s < 16; s++) begin
         rd_sel = 4'(s);
         #0.2;
         check_value($sformatf("%s w32 rd%0d", tag, s), {32'd0, rd_data},
                     (s < 12) ? mdl[0][s] : 64'd0);
         check_value($sformatf("%s w4 rd%0d", tag, s), {60'd0, rd_data4},
                     (s < 12) ? mdl[1][s] : 64'd0);
      end
      check_value($sformatf("%s w32 sat", tag), {63'd0, sat},  {63'd0, msat[0]});
      check_value($sformatf("%s w4 sat", tag),  {63'd0, sat4}, {63'd0, msat[1]});
   endtask

   task automatic step(input string tag);
      $display("txn %0d %s rst=%0b clr=%0b en=%0b max=%0d curr=%0d",
               txn, tag, reset, clear, enable, max, curr);
      txn++;
      @(posedge clk);
      model_clock();
      #1;
      check_all(tag);
   endtask

   task automatic read32(input logic [3:0] s, output logic [31:0] v);
      rd_sel = s;
      #0.2;
      v = rd_data;
   endtask

   logic [31:0] v;
   int          vals [7] = '{16, 32, 63, 64, 127, 128, 200};

   initial begin
      lim[0] = 64'hFFFF_FFFF;
      lim[1] = 64'd15;
      for (int w = 0; w < 2; w++) begin
         for (int i = 0; i < 12; i++) mdl[w][i] = 0;
         msat[w] = 1'b0;
      end
      reset = 1'b1; enable = 1'b1; clear = 1'b0; max = 32'd0; curr = 32'd77; rd_sel = 4'd0;

      step("reset");
      step("reset");
      reset = 1'b0;

      // Empty queue for five cycles.
      max = 32'd128; enable = 1'b1; curr = 32'd0;
      for (int i = 0; i < 5; i++) step("empty");
      read32(4'd0,  v); check_value("empty bin0",  {32'd0, v}, 64'd5);
      read32(4'd10, v); check_value("empty total", {32'd0, v}, 64'd5);
      read32(4'd11, v); check_value("empty peak",  {32'd0, v}, 64'd0);

      // Bin boundaries at max=128.
      foreach (vals[i]) begin
         curr = 32'(vals[i]);
         step("bounds");
      end
      read32(4'd2,  v); check_value("bounds bin2",  {32'd0, v}, 64'd1);
      read32(4'd3,  v); check_value("bounds bin3",  {32'd0, v}, 64'd1);
      read32(4'd4,  v); check_value("bounds bin4",  {32'd0, v}, 64'd1);
      read32(4'd5,  v); check_value("bounds bin5",  {32'd0, v}, 64'd1);
      read32(4'd8,  v); check_value("bounds bin8",  {32'd0, v}, 64'd1);
      read32(4'd9,  v); check_value("bounds bin9",  {32'd0, v}, 64'd2);
      read32(4'd10, v); check_value("bounds total", {32'd0, v}, 64'd12);
      read32(4'd11, v); check_value("bounds peak",  {32'd0, v}, 64'd200);

      // Degenerate capacity.
      max = 32'd0; curr = 32'd0; step("max0");
      curr = 32'd1;              step("max0");
      read32(4'd0, v); check_value("max0 bin0", {32'd0, v}, 64'd6);
      read32(4'd9, v); check_value("max0 bin9", {32'd0, v}, 64'd3);

      // Saturation of the narrow instance.
      reset = 1'b1; step("reset");
      reset = 1'b0; max = 32'd128; curr = 32'd128;
      for (int i = 0; i < 20; i++) begin
         step("sat");
         check_value($sformatf("sat w4 flag n=%0d", i + 1), {63'd0, sat4}, {63'd0, (i + 1 >= 15)});
      end
      rd_sel = 4'd9;  #0.2; check_value("sat w4 bin9",  {60'd0, rd_data4}, 64'd15);
      rd_sel = 4'd10; #0.2; check_value("sat w4 total", {60'd0, rd_data4}, 64'd15);

      // Disabled cycles must not change anything.
      enable = 1'b0;
      for (int i = 0; i < 10; i++) begin
         curr = $urandom; max = $urandom_range(0, 300);
         step("idle");
      end

      // Clear beats a qualified sample; reset beats enable.
      enable = 1'b1; clear = 1'b1; curr = 32'd5; max = 32'd128;
      step("clear");
      clear = 1'b0;
      for (int i = 0; i < 3; i++) begin
         curr = $urandom_range(0, 140);
         step("post");
      end
      reset = 1'b1; step("rst_en");
      reset = 1'b0;

      // Randomized traffic.
      for (int n = 0; n < 300; n++) begin
         longint unsigned th;
         int k;
         reset  = ($urandom_range(0, 99) == 0);
         clear  = ($urandom_range(0, 49) == 0);
         enable = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 4))
            0:       max = 32'd0;
            1:       max = 32'd128;
            2:       max = $urandom_range(1, 20);
            3:       max = $urandom;
            default: max = 32'hFFFF_FFFF;
         endcase
         k  = $urandom_range(1, 7);
         th = (longint'(k) * longint'(max) + 7) / 8;
         case ($urandom_range(0, 7))
            0:       curr = 32'd0;
            1:       curr = max;
            2:       curr = max - 32'd1;
            3:       curr = max + 32'd1;
            4:       curr = 32'(th);
            5:       curr = 32'(th) - 32'd1;
            6:       curr = $urandom_range(0, max);
            default: curr = $urandom;
         endcase
         step("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_perfmon_histogram
